// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32I data memory access controller (lane alignment, extension, timeout)
module data_mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  f3,
  input  logic [15:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        m_req,
  output logic        m_we,
  output logic [13:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Last wait count before the access is abandoned.
  localparam logic [7:0] LP_LAST_CNT = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [31:0] r_read_data;
  logic        r_done;
  logic        r_err;
  logic        r_m_req;
  logic        r_m_we;
  logic [13:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [3:0]  r_m_be;

  logic        w_f3_ok;
  logic        w_align_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

  // Legality and alignment of the request currently on the inputs.
  always_comb begin
    w_f3_ok    = 1'b0;
    w_align_ok = 1'b1;
    if (we) begin
      w_f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      w_f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (f3 == 3'b100) || (f3 == 3'b101);
    end
    case (f3[1:0])
      2'b01:   w_align_ok = ~address[0];
      2'b10:   w_align_ok = (address[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated store data; loads always fetch the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = writeData;
    if (we) begin
      case (f3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << address[1:0];
          w_wdata = {4{writeData[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << address[1:0];
          w_wdata = {2{writeData[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = writeData;
        end
      endcase
    end
  end

  // Select the addressed lane of the returned word and sign/zero extend it.
  always_comb begin
    w_shifted = m_rdata >> {r_lane, 3'b000};
    case (r_f3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load = {24'h000000, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load = {16'h0000, w_shifted[15:0]};
      default: w_load = m_rdata;
    endcase
  end

  // Access FSM with registered memory-side strobes and the ack wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_f3        <= 3'b000;
      r_lane      <= 2'b00;
      r_read_data <= 32'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_m_req     <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_addr    <= 14'd0;
      r_m_wdata   <= 32'd0;
      r_m_be      <= 4'b0000;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            if (w_f3_ok && w_align_ok) begin
              r_state   <= S_ACCESS;
              r_cnt     <= 8'd0;
              r_f3      <= f3;
              r_lane    <= address[1:0];
              r_m_req   <= 1'b1;
              r_m_we    <= we;
              r_m_addr  <= address[15:2];
              r_m_be    <= w_be;
              r_m_wdata <= w_wdata;
            end else begin
              // Rejected without touching the memory port.
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (m_ack) begin
            // Ack takes priority over a timeout expiring in the same cycle.
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_m_req <= 1'b0;
            r_m_we  <= 1'b0;
            if (!r_m_we) begin
              r_read_data <= w_load;
            end
          end else if (r_cnt == LP_LAST_CNT) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_m_req <= 1'b0;
            r_m_we  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign readData = r_read_data;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_be     = r_m_be;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  f3;
  logic [15:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        busy;
  logic        done;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [13:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        m_ack;

  int          n_cmp;
  int          n_bad;
  logic [31:0] last_rd;

  data_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .f3        (f3),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_be      (m_be),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of directed sequence");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle, then scramble inputs to show they were latched.
  task automatic issue(input logic w, input logic [2:0] f, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; f3 = f; address = a; writeData = d;
    @(negedge clk);
    req = 1'b0; we = ~w; f3 = 3'b111; address = 16'hFFFF; writeData = 32'h0;
  endtask

  // Hold m_ack low for some ACCESS cycles, then ack once; returns in the DONE cycle.
  task automatic ack_after(input int waits, input logic [31:0] rd);
    repeat (waits) @(negedge clk);
    m_ack = 1'b1; m_rdata = rd;
    @(negedge clk);
    m_ack = 1'b0; m_rdata = 32'h5A5A5A5A;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f, input logic [15:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, f, a, 32'h0);
    chk({tag, ".m_addr"}, {18'd0, m_addr}, {18'd0, a[15:2]});
    chk({tag, ".m_be"}, {28'd0, m_be}, 32'hF);
    ack_after(0, rd);
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".err"}, {31'd0, err}, 32'd0);
    chk({tag, ".readData"}, readData, exp);
    last_rd = exp;
    @(negedge clk);
    chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(1'b1, f, a, d);
    chk({tag, ".m_we"}, {31'd0, m_we}, 32'd1);
    chk({tag, ".m_addr"}, {18'd0, m_addr}, {18'd0, a[15:2]});
    chk({tag, ".m_be"}, {28'd0, m_be}, {28'd0, exp_be});
    chk({tag, ".m_wdata"}, m_wdata, exp_wd);
    ack_after(0, 32'h11111111);
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".err"}, {31'd0, err}, 32'd0);
    chk({tag, ".m_we_off"}, {31'd0, m_we}, 32'd0);
    chk({tag, ".readData_held"}, readData, last_rd);
    @(negedge clk);
  endtask

  task automatic do_bad(input string tag, input logic w, input logic [2:0] f, input logic [15:0] a);
    issue(w, f, a, 32'hFFFFFFFF);
    chk({tag, ".m_req"}, {31'd0, m_req}, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".err"}, {31'd0, err}, 32'd1);
    chk({tag, ".readData_held"}, readData, last_rd);
    @(negedge clk);
    chk({tag, ".m_req_after"}, {31'd0, m_req}, 32'd0);
    chk({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, ".done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; last_rd = 32'd0;
    rst = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'b000; address = 16'h0;
    writeData = 32'h0; m_rdata = 32'h0; m_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst.readData", readData, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done_err", {30'd0, done, err}, 32'd0);
    chk("rst.m_req_we", {30'd0, m_req, m_we}, 32'd0);
    chk("rst.m_addr", {18'd0, m_addr}, 32'd0);
    chk("rst.m_wdata", m_wdata, 32'd0);
    chk("rst.m_be", {28'd0, m_be}, 32'd0);
    rst = 1'b0;

    // lw with ack one cycle after m_req becomes visible
    issue(1'b0, 3'b010, 16'h0010, 32'h0);
    chk("lw.m_req", {31'd0, m_req}, 32'd1);
    chk("lw.m_we", {31'd0, m_we}, 32'd0);
    chk("lw.busy", {31'd0, busy}, 32'd1);
    chk("lw.m_addr", {18'd0, m_addr}, 32'h004);
    chk("lw.m_be", {28'd0, m_be}, 32'hF);
    @(negedge clk);
    chk("lw.m_addr_stable", {18'd0, m_addr}, 32'h004);
    ack_after(0, 32'hDEADBEEF);
    chk("lw.done", {31'd0, done}, 32'd1);
    chk("lw.err", {31'd0, err}, 32'd0);
    chk("lw.m_req_drop", {31'd0, m_req}, 32'd0);
    chk("lw.readData", readData, 32'hDEADBEEF);
    @(negedge clk);
    chk("lw.done_pulse", {31'd0, done}, 32'd0);
    chk("lw.busy_idle", {31'd0, busy}, 32'd0);
    chk("lw.readData_hold", readData, 32'hDEADBEEF);
    last_rd = 32'hDEADBEEF;

    // Sub-word loads and extension
    do_load("lb13",  3'b000, 16'h0013, 32'h80112233, 32'hFFFFFF80);
    do_load("lbu13", 3'b100, 16'h0013, 32'h80112233, 32'h00000080);
    do_load("lhu12", 3'b101, 16'h0012, 32'h80112233, 32'h00008011);
    do_load("lh12",  3'b001, 16'h0012, 32'h80112233, 32'hFFFF8011);
    do_load("lb10",  3'b000, 16'h0010, 32'h80112233, 32'h00000033);
    do_load("lh10",  3'b001, 16'h0010, 32'h80112233, 32'h00002233);

    // Stores
    do_store("sb21", 3'b000, 16'h0021, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
    do_store("sh22", 3'b001, 16'h0022, 32'h00001234, 4'b1100, 32'h12341234);
    do_store("sw24", 3'b010, 16'h0024, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    // Misaligned and illegal requests
    do_bad("sw06",  1'b1, 3'b010, 16'h0006);
    do_bad("lh13",  1'b0, 3'b001, 16'h0013);
    do_bad("lw02",  1'b0, 3'b010, 16'h0002);
    do_bad("ld011", 1'b0, 3'b011, 16'h0020);
    do_bad("st100", 1'b1, 3'b100, 16'h0020);

    // Timeout: m_req high for four cycles, then error completion
    issue(1'b0, 3'b010, 16'h0040, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to.m_req%0d", i), {31'd0, m_req}, 32'd1);
      @(negedge clk);
    end
    chk("to.done", {31'd0, done}, 32'd1);
    chk("to.err", {31'd0, err}, 32'd1);
    chk("to.m_req", {31'd0, m_req}, 32'd0);
    chk("to.readData", readData, last_rd);
    @(negedge clk);
    chk("to.busy_after", {31'd0, busy}, 32'd0);
    chk("to.err_after", {31'd0, err}, 32'd0);

    // Ack arriving on the last allowed cycle wins over timeout
    issue(1'b0, 3'b010, 16'h0044, 32'h0);
    ack_after(3, 32'h0BADF00D);
    chk("ackto.done", {31'd0, done}, 32'd1);
    chk("ackto.err", {31'd0, err}, 32'd0);
    chk("ackto.readData", readData, 32'h0BADF00D);
    last_rd = 32'h0BADF00D;
    @(negedge clk);

    // Request while busy is dropped, not queued
    issue(1'b0, 3'b010, 16'h0050, 32'h0);
    req = 1'b1; we = 1'b1; f3 = 3'b010; address = 16'h0060; writeData = 32'h77777777;
    @(negedge clk);
    chk("busyreq.m_addr", {18'd0, m_addr}, 32'h014);
    chk("busyreq.m_we", {31'd0, m_we}, 32'd0);
    req = 1'b0;
    ack_after(0, 32'h12345678);
    chk("busyreq.readData", readData, 32'h12345678);
    last_rd = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    chk("busyreq.not_queued", {31'd0, busy}, 32'd0);

    // m_ack in IDLE is ignored
    m_ack = 1'b1; m_rdata = 32'hFFFF0000;
    repeat (2) @(negedge clk);
    chk("idleack.done", {31'd0, done}, 32'd0);
    chk("idleack.readData", readData, last_rd);
    m_ack = 1'b0;

    // Asynchronous reset during ACCESS
    issue(1'b0, 3'b010, 16'h0070, 32'h0);
    chk("rstmid.m_req_before", {31'd0, m_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.m_req", {31'd0, m_req}, 32'd0);
    chk("rstmid.busy", {31'd0, busy}, 32'd0);
    chk("rstmid.readData", readData, 32'd0);
    chk("rstmid.m_addr", {18'd0, m_addr}, 32'd0);
    last_rd = 32'd0;
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'hAAAAAAAA;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("lateack.done", {31'd0, done}, 32'd0);
    chk("lateack.busy", {31'd0, busy}, 32'd0);
    chk("lateack.readData", readData, 32'd0);
    m_ack = 1'b0;

    // First edge after reset release accepts a request
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 1'b1; we = 1'b0; f3 = 3'b010; address = 16'h0080;
    @(negedge clk);
    req = 1'b0;
    chk("postrst.busy", {31'd0, busy}, 32'd1);
    chk("postrst.m_req", {31'd0, m_req}, 32'd1);
    chk("postrst.m_addr", {18'd0, m_addr}, 32'h020);
    ack_after(0, 32'h55AA55AA);
    chk("postrst.readData", readData, 32'h55AA55AA);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max cycles waited for m_ack before abort (1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  access request from datapath, sampled in IDLE only.
REQ-005 we  input  1  1 = store, 0 = load (UC memWrite).
REQ-006 f3  input  3  access size/sign, RV32I funct3 encoding.
REQ-007 address  input  16  byte address (datapath ALU result).
REQ-008 writeData  input  32  store data (datapath rs2).
REQ-009 readData  output  32  extended load result to datapath result mux.
REQ-010 busy  output  1  high while state is not IDLE (stall to datapath).
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle error pulse, coincident with done.
REQ-013 m_req, m_we  output  1 each  memory request and write strobe (registered).
REQ-014 m_addr  output  14  word address = address[15:2].
REQ-015 m_wdata  output  32  lane-aligned store data.
REQ-016 m_be  output  4  byte enables, bit i = byte lane i (little-endian).
REQ-017 m_rdata  input  32  memory read word, valid when m_ack high.
REQ-018 m_ack  input  1  memory completion, one or more cycles after m_req.

Function
REQ-019 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on aligned legal req; IDLE->DONE on misaligned/illegal req; ACCESS->DONE on m_ack or timeout; DONE->IDLE unconditionally.
REQ-020 In IDLE with req=1, address, we, f3, writeData SHALL be registered at that edge; later input changes SHALL not affect the access.
REQ-021 m_req, m_we, m_addr, m_be, m_wdata SHALL be driven from registers, valid from the cycle after acceptance, held stable until m_ack is sampled.
REQ-022 m_req SHALL deassert in the cycle after m_ack is sampled high; m_we SHALL be 0 whenever m_req is 0.
REQ-023 Stores: f3=000 sb, be=0001<<a[1:0], wdata={4{wd[7:0]}}; f3=001 sh, be=0011<<a[1:0], wdata={2{wd[15:0]}}; f3=010 sw, be=1111, wdata=wd.
REQ-024 Loads: m_be=1111; lane selected by a[1:0]; f3=000 lb sign-extend, 100 lbu zero-extend, 001 lh sign-extend, 101 lhu zero-extend, 010 lw.
REQ-025 Misaligned (halfword with a[0]=1, word with a[1:0]!=0) or illegal f3 (load 011/110/111, store 011..111) SHALL issue no m_req and enter DONE with err=1.
REQ-026 Wait counter SHALL reset to 0 on entering ACCESS, increment each ACCESS cycle without m_ack; at count==TIMEOUT-1 without m_ack FSM SHALL enter DONE with err=1 and drop m_req.
REQ-027 m_ack and timeout expiry in the same cycle: m_ack wins, err=0.
REQ-028 done SHALL be high exactly during the DONE cycle; total latency with immediate m_ack = 3 cycles req-to-done.
REQ-029 readData SHALL update only on a successful load completion and hold its value otherwise (stores, errors, idle).
REQ-030 req while busy SHALL be ignored (not queued); m_ack outside ACCESS SHALL be ignored.
REQ-031 busy SHALL be 0 in IDLE, so datapath may issue the next req in the cycle after done.

Reset
REQ-032 rst high SHALL immediately force IDLE and zero readData, busy, done, err, m_req, m_we, m_addr, m_wdata, m_be and the wait counter, including mid-ACCESS.
REQ-033 After rst deasserts, the first rising edge SHALL be able to accept a req.

Verification
REQ-034 lw addr=0x0010, m_rdata=0xDEADBEEF, ack 2 cycles after m_req -> m_addr=0x004, m_be=1111, done pulse, readData=0xDEADBEEF, err=0.
REQ-035 lb addr=0x0013, m_rdata=0x80112233 -> readData=0xFFFFFF80; lbu same -> 0x00000080; lhu addr=0x0012 -> 0x00008011.
REQ-036 sb addr=0x0021, wd=0x000000A5 -> m_we=1, m_be=0010, m_wdata=0xA5A5A5A5; sh addr=0x0022 wd=0x1234 -> m_be=1100, m_wdata=0x12341234.
REQ-037 sw addr=0x0006 -> no m_req ever, done=1 and err=1 two cycles after req; readData unchanged.
REQ-038 lw with m_ack held 0, TIMEOUT=4 -> m_req high 4 cycles, then done=1, err=1, m_req=0, busy=0 next cycle.
REQ-039 rst asserted in ACCESS with m_req=1 -> m_req, busy, readData 0 in the same cycle without a clock edge; late m_ack ignored.
